// File: rtl/ifetch.sv
// Instruction fetch stage: requests instruction words from memory one at a
// time, buffers up to two {pc, instr} pairs for decode, and handles
// redirects (branch/jump) and a sticky halt.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_out_if,
    output logic [31:0] imem_addr_out_if,
    input  logic        imem_valid_in_if,
    input  logic [31:0] imem_rdata_in_if,
    input  logic        stall_in_if,
    input  logic        redirect_in_if,
    input  logic [31:0] redirect_pc_in_if,
    input  logic        halt_in_if,
    output logic [31:0] instr_out_if,
    output logic [31:0] pc_out_if,
    output logic        valid_out_if,
    output logic        halt_out_if
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [31:0] req_pc;
    logic        outstanding, outstanding_nxt;

    logic [31:0] fifo_pc    [2];
    logic [31:0] fifo_instr [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count;
    logic [1:0]  count_after;

    logic        resp;
    logic        push, pop, flush, req;
    logic        fifo_empty;
    logic        out_valid;
    logic        misaligned;

    assign resp       = imem_valid_in_if && outstanding;
    assign fifo_empty = (count == 2'd0);
    assign misaligned = |redirect_pc_in_if[1:0];
    assign out_valid  = !rst && !fifo_empty && (state != HALTED);
    assign pop        = out_valid && !stall_in_if;

    // Next-state, request issue and FIFO control decisions for this cycle
    always_comb begin
        state_nxt       = state;
        fetch_pc_nxt    = fetch_pc;
        outstanding_nxt = outstanding;
        push            = 1'b0;
        flush           = 1'b0;
        req             = 1'b0;
        // Occupancy at the end of this cycle; a request is only allowed when
        // its eventual response is guaranteed a free slot.
        count_after     = count + {1'b0, push} - {1'b0, pop};

        case (state)
            RUN: begin
                if (halt_in_if) begin
                    state_nxt       = HALTED;
                    flush           = 1'b1;
                    outstanding_nxt = 1'b0;
                end else if (redirect_in_if) begin
                    flush = 1'b1;
                    if (misaligned) begin
                        state_nxt       = HALTED;
                        outstanding_nxt = 1'b0;
                    end else begin
                        fetch_pc_nxt    = redirect_pc_in_if;
                        // A response landing this cycle belongs to the old path.
                        outstanding_nxt = outstanding && !imem_valid_in_if;
                        state_nxt       = outstanding_nxt ? DRAIN : RUN;
                    end
                end else begin
                    if (resp) begin
                        push            = 1'b1;
                        outstanding_nxt = 1'b0;
                    end
                    count_after = count + {1'b0, push} - {1'b0, pop};
                    if ((!outstanding || resp) && (count_after < 2'd2)) begin
                        req             = 1'b1;
                        fetch_pc_nxt    = fetch_pc + 32'd4;
                        outstanding_nxt = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (halt_in_if || (redirect_in_if && misaligned)) begin
                    state_nxt       = HALTED;
                    flush           = 1'b1;
                    outstanding_nxt = 1'b0;
                end else begin
                    if (redirect_in_if) begin
                        fetch_pc_nxt = redirect_pc_in_if;
                    end
                    // The stale response is swallowed, then fetching resumes.
                    if (resp) begin
                        outstanding_nxt = 1'b0;
                        state_nxt       = RUN;
                    end
                end
            end
            HALTED: begin
                flush           = 1'b1;
                outstanding_nxt = 1'b0;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Control state: FSM, fetch PC and in-flight flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            outstanding <= 1'b0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            outstanding <= outstanding_nxt;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_after;
        end
    end

    // Datapath: remember the address in flight and store returned words
    always_ff @(posedge clk) begin
        if (req) begin
            req_pc <= fetch_pc;
        end
        if (push) begin
            fifo_pc[wr_ptr]    <= req_pc;
            fifo_instr[wr_ptr] <= imem_rdata_in_if;
        end
    end

    assign imem_req_out_if  = req && !rst;
    assign imem_addr_out_if = imem_req_out_if ? fetch_pc : 32'h0;
    assign valid_out_if     = out_valid;
    assign instr_out_if     = (rst || fifo_empty) ? NOP   : fifo_instr[rd_ptr];
    assign pc_out_if        = (rst || fifo_empty) ? 32'h0 : fifo_pc[rd_ptr];
    assign halt_out_if      = !rst && (state == HALTED);

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a small variable-latency memory responder.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_valid, stall, redirect, halt_in;
    logic [31:0] imem_addr, imem_rdata, redirect_pc;
    logic [31:0] instr, pc;
    logic        valid, halt_out;

    always #5 clk = ~clk;

    ifetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .rst               (rst),
        .imem_req_out_if   (imem_req),
        .imem_addr_out_if  (imem_addr),
        .imem_valid_in_if  (imem_valid),
        .imem_rdata_in_if  (imem_rdata),
        .stall_in_if       (stall),
        .redirect_in_if    (redirect),
        .redirect_pc_in_if (redirect_pc),
        .halt_in_if        (halt_in),
        .instr_out_if      (instr),
        .pc_out_if         (pc),
        .valid_out_if      (valid),
        .halt_out_if       (halt_out)
    );

    typedef struct {
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [11];

    int n_chk  = 0;
    int n_fail = 0;

    // Memory model: one pending request, answered lat cycles later with ~addr.
    int          lat = 1;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_cnt = 0;

    logic        s_req, s_valid, s_halt;
    logic [31:0] s_addr, s_pc, s_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive memory response, sample outputs, advance memory.
    task automatic tick();
        if (pend && pend_cnt == 0) begin
            imem_valid = 1'b1;
            imem_rdata = ~pend_addr;
        end else begin
            imem_valid = 1'b0;
            imem_rdata = 32'h0;
        end
        #3;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = valid;
        s_pc    = pc;
        s_instr = instr;
        s_halt  = halt_out;
        @(posedge clk);
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (imem_valid) pend = 1'b0;
            else if (pend) pend_cnt--;
            if (s_req) begin
                pend      = 1'b1;
                pend_addr = s_addr;
                pend_cnt  = lat - 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; halt_in = 1'b0;
        redirect_pc = 32'h0;
        tick();
        tick();
        chk("rst_req", {31'h0, s_req}, 32'h0);
        chk("rst_addr", s_addr, 32'h0);
        chk("rst_valid", {31'h0, s_valid}, 32'h0);
        chk("rst_halt", {31'h0, s_halt}, 32'h0);
        chk("rst_instr", s_instr, 32'h0000_0013);
        chk("rst_pc", s_pc, 32'h0);
        rst = 1'b0;
    endtask

    task automatic chk_req(input string name, input logic r, input logic [31:0] a);
        chk({name, "_req"}, {31'h0, s_req}, {31'h0, r});
        chk({name, "_addr"}, s_addr, a);
    endtask

    task automatic chk_out(input string name, input logic v, input logic [31:0] p);
        chk({name, "_valid"}, {31'h0, s_valid}, {31'h0, v});
        if (v) begin
            chk({name, "_pc"}, s_pc, p);
            chk({name, "_instr"}, s_instr, ~p);
        end else begin
            chk({name, "_nop"}, s_instr, 32'h0000_0013);
        end
    endtask

    initial begin
        // Streaming with a 5-cycle stall in the middle (1-cycle memory).
        vecs[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h4};
        vecs[4]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h4};
        vecs[5]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h4};
        vecs[6]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h4};
        vecs[7]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h4};
        vecs[8]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h4};
        vecs[9]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h8};
        vecs[10] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'hC};

        imem_valid = 1'b0; imem_rdata = 32'h0;
        @(posedge clk); #1;

        // Table-driven streaming/stall run
        lat = 1;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            stall = vecs[i].stall;
            tick();
            chk_req($sformatf("stream%0d", i), vecs[i].exp_req, vecs[i].exp_addr);
            chk_out($sformatf("stream%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
        end
        stall = 1'b0;

        // Redirect to 0x100 while the 0x10 request is outstanding (3-cycle memory)
        lat = 1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_req($sformatf("pre%0d", i), 1'b1, 32'(i * 4));
        end
        lat = 3;
        tick();
        chk_req("c4", 1'b1, 32'h10);
        chk_out("c4", 1'b1, 32'h8);
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        chk_req("redir", 1'b0, 32'h0);
        redirect = 1'b0;
        tick();
        chk_req("drain1", 1'b0, 32'h0);
        chk_out("drain1", 1'b0, 32'h0);
        tick();
        chk_req("drain2", 1'b0, 32'h0);
        chk_out("drain2", 1'b0, 32'h0);
        lat = 1;
        tick();
        chk_req("resume", 1'b1, 32'h100);
        tick();
        chk_req("resume2", 1'b1, 32'h104);
        chk_out("resume2", 1'b0, 32'h0);
        tick();
        chk_req("resume3", 1'b1, 32'h108);
        chk_out("resume3", 1'b1, 32'h100);

        // Redirect near the top of memory; fetch address wraps to zero
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        chk_req("wrapredir", 1'b0, 32'h0);
        chk_out("wrapredir", 1'b1, 32'h104);
        redirect = 1'b0;
        tick();
        chk_req("wrap0", 1'b1, 32'hFFFF_FFF8);
        chk_out("wrap0", 1'b0, 32'h0);
        tick();
        chk_req("wrap1", 1'b1, 32'hFFFF_FFFC);
        tick();
        chk_req("wrap2", 1'b1, 32'h0000_0000);
        chk_out("wrap2", 1'b1, 32'hFFFF_FFF8);
        tick();
        chk_out("wrap3", 1'b1, 32'hFFFF_FFFC);
        tick();
        chk_out("wrap4", 1'b1, 32'h0000_0000);

        // Misaligned redirect halts fetch
        redirect = 1'b1; redirect_pc = 32'h102;
        tick();
        chk_req("misredir", 1'b0, 32'h0);
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("mis_halt%0d", i), {31'h0, s_halt}, 32'h1);
            chk_req($sformatf("mis%0d", i), 1'b0, 32'h0);
            chk_out($sformatf("mis%0d", i), 1'b0, 32'h0);
        end

        // halt_in pulse at cycle 6 is sticky until reset
        lat = 1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_req($sformatf("h_pre%0d", i), 1'b1, 32'(i * 4));
        end
        halt_in = 1'b1;
        tick();
        chk_req("h_pulse", 1'b0, 32'h0);
        chk("h_pulse_halt", {31'h0, s_halt}, 32'h0);
        halt_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("h_stick%0d", i), {31'h0, s_halt}, 32'h1);
            chk_req($sformatf("h_stick%0d", i), 1'b0, 32'h0);
            chk_out($sformatf("h_stick%0d", i), 1'b0, 32'h0);
        end
        do_reset();
        tick();
        chk_req("h_restart0", 1'b1, 32'h0);
        chk("h_restart_halt", {31'h0, s_halt}, 32'h0);
        tick();
        chk_req("h_restart1", 1'b1, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 imem_req_out_if  output  1  instruction-memory read request, one-cycle pulse per request.
REQ-005 imem_addr_out_if  output  32  word-aligned read address, valid while imem_req_out_if=1.
REQ-006 imem_valid_in_if  input  1  response strobe; arrives 1 or more cycles after its request.
REQ-007 imem_rdata_in_if  input  32  instruction word, valid with imem_valid_in_if.
REQ-008 stall_in_if  input  1  decode cannot accept; hold current output.
REQ-009 redirect_in_if  input  1  branch/jump taken; refetch from redirect_pc_in_if.
REQ-010 redirect_pc_in_if  input  32  redirect target.
REQ-011 halt_in_if  input  1  halt from a downstream stage (invalid opcode/size); sticky stop.
REQ-012 instr_out_if  output  32  instruction to decode (feeds instr_in_id).
REQ-013 pc_out_if  output  32  PC of instr_out_if (feeds pc_in_id).
REQ-014 valid_out_if  output  1  instr_out_if/pc_out_if hold a real instruction.
REQ-015 halt_out_if  output  1  fetch halted (feeds halt_in_id).

Function
REQ-016 States SHALL be RUN, DRAIN, HALTED; internal fetch_pc (32b), 2-entry {pc,instr} FIFO, outstanding flag (max 1 request in flight).
REQ-017 RUN: issue request when outstanding=0, FIFO count<2, no redirect/halt this cycle; addr=fetch_pc; fetch_pc+=4 (mod 2^32, wraps FFFF_FFFC->0000_0000); outstanding<=1.
REQ-018 Response in RUN: push {pc of that request, imem_rdata_in_if} to FIFO; outstanding<=0; next request may issue the same cycle.
REQ-019 Output: instr_out_if/pc_out_if = FIFO head; valid_out_if = FIFO non-empty and state!=HALTED; pop when valid_out_if=1 and stall_in_if=0.
REQ-020 FIFO full (2) SHALL block new requests; push and pop in same cycle SHALL keep count unchanged; empty output SHALL show valid_out_if=0 with instr_out_if=32'h0000_0013 (NOP).
REQ-021 Redirect (RUN, redirect_in_if=1): FIFO flushed, fetch_pc<=redirect_pc_in_if, no request that cycle; a response arriving that same cycle is discarded; if outstanding remains after it, go DRAIN, else stay RUN.
REQ-022 DRAIN: no requests; next response discarded, outstanding<=0, go RUN; further redirect in DRAIN only updates fetch_pc.
REQ-023 Redirect target with bits[1:0]!=0 SHALL go HALTED instead of redirecting.
REQ-024 halt_in_if=1 in any state: go HALTED next cycle; halt has priority over redirect.
REQ-025 HALTED: no requests, responses discarded, valid_out_if=0, halt_out_if=1; exit only by rst.
REQ-026 First request SHALL issue in the first cycle after rst deasserts.

Reset
REQ-027 rst=1 SHALL set state RUN, fetch_pc=RESET_PC, FIFO empty, outstanding=0, imem_req_out_if=0, imem_addr_out_if=0, valid_out_if=0, halt_out_if=0, instr_out_if=32'h0000_0013, pc_out_if=0.
REQ-028 rst mid-request SHALL abandon the in-flight request; a response arriving after reset SHALL be discarded unless a post-reset request is outstanding.

Verification
REQ-029 Streaming, 1-cycle memory, stall=0: rst release -> requests at 0,4,8; outputs pc 0,4,8 each valid one cycle, in order, no duplicates.
REQ-030 stall_in_if=1 for 5 cycles -> output holds pc 0x4; at most 2 buffered + 0 outstanding; after release pcs 0x4,0x8,0xC in order.
REQ-031 Redirect to 0x100 while request for 0x10 outstanding, response 3 cycles later -> that response discarded; next output pc 0x100; no request until DRAIN exits.
REQ-032 Redirect to 0x102 -> halt_out_if=1 next cycle, valid_out_if=0, no further requests.
REQ-033 halt_in_if pulse at cycle 6 -> HALTED persists after pulse; rst restores fetch from RESET_PC.
REQ-034 Redirect to 0xFFFF_FFF8, stall=0 -> fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
